// File: rtl/pwm_phase_gen.sv
// Multi-channel phase-shifted PWM: one shared period counter, per-channel duty/phase, settings double-buffered to the period boundary.
// pwm/sync are registered (1-cycle latency from cnt); writes are always accepted, no backpressure.
module pwm_phase_gen #(
  parameter  int CHANNELS   = 8,
  parameter  int WIDTH      = 8,
  parameter  int DEF_PERIOD = 2**WIDTH - 1,
  localparam int AW         = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                wr_en,
  input  logic [1:0]          wr_sel,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm,
  output logic                sync
);

  localparam logic [WIDTH-1:0] LP_PERIOD  = WIDTH'(DEF_PERIOD);
  localparam logic [WIDTH-1:0] LP_DUTY    = WIDTH'((DEF_PERIOD + 1) / 2);
  localparam int               LP_PH_STEP = (DEF_PERIOD + 1) / CHANNELS;
  localparam logic [AW:0]      LP_NCH     = (AW+1)'(CHANNELS);

  logic [WIDTH-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_period_pend;
  logic [WIDTH-1:0]    r_period_act;
  logic [WIDTH-1:0]    r_duty_pend  [CHANNELS];
  logic [WIDTH-1:0]    r_duty_act   [CHANNELS];
  logic [WIDTH-1:0]    r_phase_pend [CHANNELS];
  logic [WIDTH-1:0]    r_phase_act  [CHANNELS];
  logic [CHANNELS-1:0] r_pwm;
  logic                r_sync;

  logic [WIDTH-1:0]    w_duty_nxt  [CHANNELS];
  logic [WIDTH-1:0]    w_phase_nxt [CHANNELS];
  logic [WIDTH-1:0]    w_period_nxt;
  logic                w_addr_ok;
  logic                w_wrap;
  logic                w_apply;
  logic [WIDTH:0]      w_len;
  logic [CHANNELS-1:0] w_pwm_nxt;

  assign w_addr_ok = ({1'b0, wr_addr} < LP_NCH);
  assign w_wrap    = en && (r_cnt == r_period_act);
  assign w_apply   = !en || w_wrap;
  assign w_len     = {1'b0, r_period_act} + {{WIDTH{1'b0}}, 1'b1};

  // Pending image including this cycle's write, so a write in the wrap cycle lands in the same boundary.
  always_comb begin
    w_duty_nxt   = r_duty_pend;
    w_phase_nxt  = r_phase_pend;
    w_period_nxt = r_period_pend;
    if (wr_en) begin
      case (wr_sel)
        2'b00:   if (w_addr_ok) w_duty_nxt[wr_addr] = wr_data;
        2'b01:   if (w_addr_ok) w_phase_nxt[wr_addr] = wr_data;
        2'b10:   w_period_nxt = wr_data;
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] w_ph;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_lc;
    // A phase beyond the period has no meaningful position, so it collapses to 0.
    assign w_ph         = (r_phase_act[g] <= r_period_act) ? r_phase_act[g] : '0;
    assign w_sum        = {1'b0, r_cnt} + {1'b0, w_ph};
    assign w_lc         = (w_sum > {1'b0, r_period_act}) ? (w_sum - w_len) : w_sum;
    assign w_pwm_nxt[g] = en && (w_lc < {1'b0, r_duty_act[g]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_pwm         <= '0;
      r_sync        <= 1'b0;
      r_period_pend <= LP_PERIOD;
      r_period_act  <= LP_PERIOD;
      for (int n = 0; n < CHANNELS; n++) begin
        r_duty_pend[n]  <= LP_DUTY;
        r_duty_act[n]   <= LP_DUTY;
        r_phase_pend[n] <= WIDTH'(n * LP_PH_STEP);
        r_phase_act[n]  <= WIDTH'(n * LP_PH_STEP);
      end
    end else begin
      r_duty_pend   <= w_duty_nxt;
      r_phase_pend  <= w_phase_nxt;
      r_period_pend <= w_period_nxt;
      if (w_apply) begin
        r_duty_act   <= w_duty_nxt;
        r_phase_act  <= w_phase_nxt;
        r_period_act <= w_period_nxt;
      end
      if (w_apply) r_cnt <= '0;
      else         r_cnt <= r_cnt + WIDTH'(1);
      r_pwm  <= w_pwm_nxt;
      r_sync <= en && (r_cnt == '0);
    end
  end

  assign pwm  = r_pwm;
  assign sync = r_sync;

endmodule

// File: tb/tb_pwm_phase_gen.sv
// Directed bench for pwm_phase_gen with CHANNELS=4, WIDTH=4: hand-derived pwm/sync patterns per scenario.
module tb_pwm_phase_gen;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       wr_en;
  logic [1:0] wr_sel;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] pwm;
  logic       sync;

  int n_chk;
  int n_fail;

  // Default pattern (P=15, duty 8, phases 0/4/8/12), indexed by cnt/4; bit n = channel n.
  logic [3:0] def_tab [4]  = '{4'b0011, 4'b1001, 4'b1100, 4'b0110};
  // P=9, ch0 duty 10, ch3 phase 12 -> effective 0.
  logic [3:0] tab_a   [10] = '{4'b1011, 4'b1011, 4'b1111, 4'b1111, 4'b1101,
                               4'b1101, 4'b1111, 4'b1111, 4'b0111, 4'b0111};
  // Same as tab_a with ch2 duty 0.
  logic [3:0] tab_b   [10] = '{4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1001,
                               4'b1001, 4'b1011, 4'b1011, 4'b0011, 4'b0011};
  // P=9, defaults except ch2 phase 7 duty 5, ch3 phase 12.
  logic [3:0] tab_c   [10] = '{4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b1101,
                               4'b1101, 4'b1111, 4'b1111, 4'b0010, 4'b0010};
  // P=15 defaults with ch0 duty 2.
  logic [3:0] tab_d   [16] = '{4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
                               4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0110, 4'b0110, 4'b0110, 4'b0110};

  pwm_phase_gen #(.CHANNELS(4), .WIDTH(4), .DEF_PERIOD(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .pwm     (pwm),
    .sync    (sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b0;
    wr_en   = 1'b0;
    wr_sel  = 2'b00;
    wr_addr = 2'd0;
    wr_data = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (pwm !== 4'b0000 || sync !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state pwm=%b sync=%b, want pwm=0000 sync=0", pwm, sync);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (pwm !== 4'b0000 || sync !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_en_low pwm=%b sync=%b, want pwm=0000 sync=0", pwm, sync);
    end
  endtask

  task automatic test_default();
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      n_chk++;
      if (pwm !== def_tab[(k % 16) / 4] || sync !== ((k % 16) == 0)) begin
        n_fail++;
        $display("FAIL default k=%0d pwm=%b sync=%b, want pwm=%b sync=%b",
                 k, pwm, sync, def_tab[(k % 16) / 4], ((k % 16) == 0));
      end
    end
  endtask

  task automatic test_duty_midperiod();
    logic [3:0] exp;
    int         ones;
    int         c;
    ones = 0;
    do_reset();
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      c   = k % 16;
      exp = def_tab[c / 4];
      if (k >= 16) exp[1] = (c >= 12 && c <= 14);
      if (k >= 16 && pwm[1] === 1'b1) ones++;
      if (k >= 5) begin
        n_chk++;
        if (pwm !== exp || sync !== (c == 0)) begin
          n_fail++;
          $display("FAIL duty_midperiod k=%0d pwm=%b sync=%b, want pwm=%b sync=%b",
                   k, pwm, sync, exp, (c == 0));
        end
      end
      wr_en   = (k == 4);
      wr_sel  = 2'b00;
      wr_addr = 2'd1;
      wr_data = 4'd3;
    end
    wr_en = 1'b0;
    n_chk++;
    if (ones != 3) begin
      n_fail++;
      $display("FAIL duty_ch1_high_count got=%0d want=3", ones);
    end
  endtask

  task automatic test_period_wrap();
    logic [3:0] exp;
    logic       exp_sync;
    int         c;
    do_reset();
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 37; k++) begin
      @(negedge clk);
      if (k < 16) begin
        exp      = def_tab[k / 4];
        exp_sync = (k == 0);
      end else begin
        c        = (k - 16) % 10;
        exp      = (k < 26) ? tab_a[c] : tab_b[c];
        exp_sync = (c == 0);
      end
      n_chk++;
      if (pwm !== exp || sync !== exp_sync) begin
        n_fail++;
        $display("FAIL period_wrap k=%0d pwm=%b sync=%b, want pwm=%b sync=%b",
                 k, pwm, sync, exp, exp_sync);
      end
      wr_en = 1'b0;
      if (k == 12) begin
        wr_en = 1'b1; wr_sel = 2'b10; wr_addr = 2'd0; wr_data = 4'd9;
      end else if (k == 14) begin
        wr_en = 1'b1; wr_sel = 2'b00; wr_addr = 2'd0; wr_data = 4'd10;
      end else if (k == 16) begin
        wr_en = 1'b1; wr_sel = 2'b00; wr_addr = 2'd2; wr_data = 4'd0;
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_phase_wrap();
    do_reset();
    wr_en = 1'b1; wr_sel = 2'b10; wr_addr = 2'd0; wr_data = 4'd9;
    @(negedge clk);
    wr_sel = 2'b01; wr_addr = 2'd3; wr_data = 4'd12;
    @(negedge clk);
    wr_sel = 2'b01; wr_addr = 2'd2; wr_data = 4'd7;
    @(negedge clk);
    wr_sel = 2'b00; wr_addr = 2'd2; wr_data = 4'd5;
    @(negedge clk);
    wr_en = 1'b0;
    en    = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_chk++;
      if (pwm !== tab_c[k % 10] || sync !== ((k % 10) == 0)) begin
        n_fail++;
        $display("FAIL phase_wrap k=%0d pwm=%b sync=%b, want pwm=%b sync=%b",
                 k, pwm, sync, tab_c[k % 10], ((k % 10) == 0));
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [3:0] exp;
    logic       exp_sync;
    do_reset();
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      if (k < 7) begin
        exp      = def_tab[k / 4];
        exp_sync = (k == 0);
      end else if (k < 12) begin
        exp      = 4'b0000;
        exp_sync = 1'b0;
      end else begin
        exp      = tab_d[k - 12];
        exp_sync = (k == 12);
      end
      n_chk++;
      if (pwm !== exp || sync !== exp_sync) begin
        n_fail++;
        $display("FAIL enable_drop k=%0d pwm=%b sync=%b, want pwm=%b sync=%b",
                 k, pwm, sync, exp, exp_sync);
      end
      en      = !(k >= 6 && k <= 10);
      wr_en   = (k == 7);
      wr_sel  = 2'b00;
      wr_addr = 2'd0;
      wr_data = 4'd2;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_async_reset();
    wr_en = 1'b0;
    en    = 1'b0;
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (k == 1) begin
        wr_en = 1'b1; wr_sel = 2'b10; wr_addr = 2'd0; wr_data = 4'd9;
      end else if (k == 2) begin
        wr_en = 1'b1; wr_sel = 2'b00; wr_addr = 2'd1; wr_data = 4'd1;
      end
    end
    n_chk++;
    if (pwm !== tab_d[6]) begin
      n_fail++;
      $display("FAIL pre_reset pwm=%b want=%b", pwm, tab_d[6]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (pwm !== 4'b0000 || sync !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_immediate pwm=%b sync=%b, want pwm=0000 sync=0", pwm, sync);
    end
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (pwm !== 4'b0000 || sync !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_held pwm=%b sync=%b, want pwm=0000 sync=0", pwm, sync);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      n_chk++;
      if (pwm !== def_tab[(k % 16) / 4] || sync !== ((k % 16) == 0)) begin
        n_fail++;
        $display("FAIL after_reset k=%0d pwm=%b sync=%b, want pwm=%b sync=%b",
                 k, pwm, sync, def_tab[(k % 16) / 4], ((k % 16) == 0));
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_default();
    test_duty_midperiod();
    test_period_wrap();
    test_phase_wrap();
    test_enable_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_phase_gen.md
# pwm_phase_gen

Parametrised multi-channel phase-shifted PWM generator, the successor to the fixed 8-channel shifted PWM block. One shared period counter drives CHANNELS outputs, each with its own programmable duty and phase offset. All settings are double-buffered and applied only at the period boundary, so outputs never glitch. A sync pulse marks each period start for downstream sampling/ADC triggering.

## Interface
- CHANNELS, 8, number of PWM outputs (≥2)
- WIDTH, 8, counter/duty/phase/period width in bits
- DEF_PERIOD, 2**WIDTH-1, period register reset value (cycle count minus one)
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; low = counter held, outputs low
- wr_en  in  1  register write strobe, one write per cycle
- wr_sel  in  2  target: 00 duty, 01 phase, 10 period, 11 ignored
- wr_addr  in  max(1,$clog2(CHANNELS))  channel index for duty/phase (ignored for period); index ≥ CHANNELS ignored
- wr_data  in  WIDTH  write value
- pwm  out  CHANNELS  registered PWM outputs, bit n = channel n
- sync  out  1  one-cycle pulse at period start

## Operation
- Registers: per-channel pending/active duty and phase; pending/active period. Writes always land in pending.
- Reset values (async, on rst_n low): cnt 0, pwm all 0, sync 0; period = DEF_PERIOD; duty_n = (DEF_PERIOD+1)/2; phase_n = n*((DEF_PERIOD+1)/CHANNELS) (integer division), both pending and active. With en high after reset the block reproduces the legacy 50 % evenly shifted pattern.
- Counter: cnt counts 0..P (P = active period), wraps to 0. Wrap cycle = cycle where cnt == P.
- Update: on wrap cycle, active <= pending; a write in that same cycle is included (write-through). Non-wrap writes wait for next wrap.
- Local count per channel: s = cnt + ph computed in WIDTH+1 bits; lc = s − (P+1) if s > P else s. Effective ph = phase_n if phase_n ≤ P else 0.
- Compare: pwm_n next = en & (lc < duty_n). duty 0 → constant low; duty ≥ P+1 → constant high.
- P = 0 legal: period of 1 cycle, sync high every cycle while en.
- en low: cnt forced to 0, pwm and sync 0 next cycle, active <= pending every cycle (immediate apply). en rising: first enabled cycle counts from cnt 0.

## Timing
- pwm and sync are registered: values at cycle k+1 reflect cnt at cycle k (1-cycle latency).
- sync high exactly in cycles where pwm reflects cnt == 0 and en was high; period of sync = P+1 cycles.
- Active values change only between cnt == P and cnt == 0; no partial period ever uses mixed settings.
- Write-to-effect latency: ≤ P+1 cycles to boundary, plus 1 output register cycle.
- rst_n assertion mid-period: outputs 0 immediately (async), all registers reload reset values; first rising edge after rst_n release with en high begins at cnt 0.

## Test plan
- CHANNELS=4, WIDTH=4, defaults, en=1 after reset -> each pwm_n high 8 of 16 cycles, pwm_n lags pwm_(n+1)... phases 0,4,8,12: channel n rises 4n cycles earlier in local count; sync every 16 cycles.
- Write duty ch1 = 3 mid-period (cnt=5) -> ch1 unchanged until wrap, then high exactly 3 cycles per period; other channels unaffected.
- Write period = 9 and duty ch0 = 10 in wrap cycle -> same boundary applies both: sync every 10 cycles, ch0 constant high; duty 0 on ch2 -> constant low.
- Phase ch3 = 12 with period 9 -> effective phase 0, ch3 aligned with ch0; phase 7, duty 5 -> lc wrap correct: high when cnt ∈ {0,1,2,3,4} shifted by 7 mod 10 (cnt 3..7).
- Drop en for 5 cycles mid-period -> pwm/sync 0 next cycle, cnt held 0; pending write during en low applied immediately; re-enable restarts from cnt 0 with sync after 1 cycle.
- Assert rst_n low at cnt=7 after reprogramming -> outputs 0 without clock, registers back to defaults, pattern identical to first test after release.
